multiword_add_ctrl: RTL and testbench



---
 rtl/mwadd_pkg.sv | 25 ++
 rtl/multiword_add_ctrl_prefix.sv | 43 ++++
 rtl/multiword_add_ctrl.sv | 133 +++++++++++++
 tb/tb_multiword_add_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mwadd_pkg.sv
// +----------------------------------------------------------------------+
// | mwadd_pkg : shared types/constants for the multiword add sequencer    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package mwadd_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_WORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Word index width; a single-word build still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multiword_add_ctrl_prefix.sv
// +----------------------------------------------------------------------+
// | prefix : combinational Kogge-Stone adder, Width bits with carry in    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module prefix #(
  parameter int Width = 8
) (
  input  logic [Width-1:0] i_a,
  input  logic [Width-1:0] i_b,
  input  logic             i_ci,
  output logic [Width-1:0] o_s,
  output logic             o_co
);

  logic [Width-1:0] w_g, w_p, w_gn, w_pn;
  logic [Width:0]   w_c;

  always_comb begin
    w_g  = i_a & i_b;
    w_p  = i_a ^ i_b;
    w_gn = w_g;
    w_pn = w_p;
    // Each level doubles the span of the group generate/propagate terms.
    for (int l = 0; (1 << l) < Width; l++) begin
      w_gn = w_g;
      w_pn = w_p;
      for (int i = (1 << l); i < Width; i++) begin
        w_gn[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
        w_pn[i] = w_p[i] & w_p[i - (1 << l)];
      end
      w_g = w_gn;
      w_p = w_pn;
    end
    w_c  = {w_g | (w_p & {Width{i_ci}}), i_ci};
    o_s  = (i_a ^ i_b) ^ w_c[Width-1:0];
    o_co = w_c[Width];
  end

endmodule

`default_nettype wire

// File: rtl/multiword_add_ctrl.sv
// +----------------------------------------------------------------------+
// | multiword_add_ctrl : WIDTH*WORDS-bit add, one word per cycle, LSW 1st |
// | Optional MWADD_OVF_EN adds signed-overflow output. Rev 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

module multiword_add_ctrl
  import mwadd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_ci,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_co
`ifdef MWADD_OVF_EN
  ,
  output logic                   out_ovf
`endif
);

  localparam int TOTAL = WIDTH * WORDS;
  localparam int IDXW  = idx_width(WORDS);

  state_t            r_state, w_state_nxt;
  logic [TOTAL-1:0]  r_a, r_b, r_sum, w_sum_nxt;
  logic              r_carry, r_co;
  logic [IDXW-1:0]   r_idx;
  logic [WIDTH-1:0]  w_s;
  logic              w_co, w_last;

  prefix #(.Width(WIDTH)) u_prefix (
    .i_a  (r_a[WIDTH-1:0]),
    .i_b  (r_b[WIDTH-1:0]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  assign w_last = (r_idx == IDXW'(WORDS - 1));

  // Each word's sum enters at the top so the LSW ends up at the bottom.
  if (WORDS > 1) begin : g_sum_multi
    assign w_sum_nxt = {w_s, r_sum[TOTAL-1:WIDTH]};
  end else begin : g_sum_single
    assign w_sum_nxt = w_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_ci;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> WIDTH;
          r_b     <= r_b >> WIDTH;
          r_sum   <= w_sum_nxt;
          r_carry <= w_co;
          r_idx   <= r_idx + IDXW'(1);
          if (w_last) r_co <= w_co;
        end
        default: ;
      endcase
    end
  end

  assign out_sum = r_sum;
  assign out_co  = r_co;

`ifdef MWADD_OVF_EN
  logic r_ovf;

  // Carry into the MSB is recovered from the sum bit and the operand bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_RUN && w_last) begin
      r_ovf <= (w_s[WIDTH-1] ^ r_a[WIDTH-1] ^ r_b[WIDTH-1]) ^ w_co;
    end
  end

  assign out_ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multiword_add_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_multiword_add_ctrl : scoreboard bench, 8x4 and 16x1 configurations |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_multiword_add_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: WIDTH=8, WORDS=4
  logic        a_in_valid, a_in_ready, a_in_ci, a_out_valid, a_out_ready, a_out_co;
  logic [31:0] a_in_a, a_in_b, a_out_sum;
`ifdef MWADD_OVF_EN
  logic        a_out_ovf;
`endif

  // DUT B: WIDTH=16, WORDS=1
  logic        b_in_valid, b_in_ready, b_in_ci, b_out_valid, b_out_ready, b_out_co;
  logic [15:0] b_in_a, b_in_b, b_out_sum;
`ifdef MWADD_OVF_EN
  logic        b_out_ovf;
`endif

  multiword_add_ctrl #(.WIDTH(8), .WORDS(4)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_a      (a_in_a),
    .in_b      (a_in_b),
    .in_ci     (a_in_ci),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_sum   (a_out_sum),
    .out_co    (a_out_co)
`ifdef MWADD_OVF_EN
    ,
    .out_ovf   (a_out_ovf)
`endif
  );

  multiword_add_ctrl #(.WIDTH(16), .WORDS(1)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_a      (b_in_a),
    .in_b      (b_in_b),
    .in_ci     (b_in_ci),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_sum   (b_out_sum),
    .out_co    (b_out_co)
`ifdef MWADD_OVF_EN
    ,
    .out_ovf   (b_out_ovf)
`endif
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        co;
    logic        ovf;
  } exp_a_t;

  typedef struct packed {
    logic [15:0] sum;
    logic        co;
    logic        ovf;
  } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];
  exp_a_t ea;
  exp_b_t eb;
  int     acc_a = 0;
  int     acc_b = 0;
  logic   a_prev_v = 1'b0;
  logic   b_prev_v = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_a(input logic [31:0] a, input logic [31:0] b, input logic ci);
    int          n;
    logic [32:0] full;
    exp_a_t      e;
    n = 0;
    while (!a_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check_eq("a_ready_timeout", 64'(n), 64'd0);
    a_in_valid = 1'b1;
    a_in_a     = a;
    a_in_b     = b;
    a_in_ci    = ci;
    @(posedge clk); #1;
    acc_a      = cyc;
    a_in_valid = 1'b0;
    full  = {1'b0, a} + {1'b0, b} + 33'(ci);
    e.sum = full[31:0];
    e.co  = full[32];
    e.ovf = (a[31] == b[31]) && (full[31] != a[31]);
    qa.push_back(e);
  endtask

  task automatic send_b(input logic [15:0] a, input logic [15:0] b, input logic ci);
    int          n;
    logic [16:0] full;
    exp_b_t      e;
    n = 0;
    while (!b_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check_eq("b_ready_timeout", 64'(n), 64'd0);
    b_in_valid = 1'b1;
    b_in_a     = a;
    b_in_b     = b;
    b_in_ci    = ci;
    @(posedge clk); #1;
    acc_b      = cyc;
    b_in_valid = 1'b0;
    full  = {1'b0, a} + {1'b0, b} + 17'(ci);
    e.sum = full[15:0];
    e.co  = full[16];
    e.ovf = (a[15] == b[15]) && (full[15] != a[15]);
    qb.push_back(e);
  endtask

  task automatic wait_idle(input logic is_b);
    int n;
    n = 0;
    while (((is_b ? qb.size() : qa.size()) != 0 || !(is_b ? b_in_ready : a_in_ready)) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check_eq(is_b ? "b_idle_timeout" : "a_idle_timeout", 64'(n), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_out_valid && !a_prev_v) check_eq("a_latency", 64'(cyc - acc_a), 64'd4);
      a_prev_v <= a_out_valid;
      if (a_out_valid && a_out_ready) begin
        check_eq("a_sb_nonempty", 64'(qa.size() != 0), 64'd1);
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          check_eq("a_sum", 64'(a_out_sum), 64'(ea.sum));
          check_eq("a_co", 64'(a_out_co), 64'(ea.co));
`ifdef MWADD_OVF_EN
          check_eq("a_ovf", 64'(a_out_ovf), 64'(ea.ovf));
`endif
        end
      end
    end else begin
      a_prev_v <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_out_valid && !b_prev_v) check_eq("b_latency", 64'(cyc - acc_b), 64'd1);
      b_prev_v <= b_out_valid;
      if (b_out_valid && b_out_ready) begin
        check_eq("b_sb_nonempty", 64'(qb.size() != 0), 64'd1);
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          check_eq("b_sum", 64'(b_out_sum), 64'(eb.sum));
          check_eq("b_co", 64'(b_out_co), 64'(eb.co));
`ifdef MWADD_OVF_EN
          check_eq("b_ovf", 64'(b_out_ovf), 64'(eb.ovf));
`endif
        end
      end
    end else begin
      b_prev_v <= 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          prev;
    int          n;
    logic [31:0] ra, rb;
    rst_n       = 1'b0;
    a_in_valid  = 1'b0; a_in_a = '0; a_in_b = '0; a_in_ci = 1'b0; a_out_ready = 1'b0;
    b_in_valid  = 1'b0; b_in_a = '0; b_in_b = '0; b_in_ci = 1'b0; b_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    check_eq("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    check_eq("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    check_eq("rst_a_out_sum", 64'(a_out_sum), 64'd0);
    check_eq("rst_a_out_co", 64'(a_out_co), 64'd0);
    check_eq("rst_b_in_ready", 64'(b_in_ready), 64'd1);

    // Full carry ripple across all four words
    a_out_ready = 1'b1;
    send_a(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_idle(1'b0);

    // Held output with competing in_valid during RUN and DONE
    a_out_ready = 1'b0;
    send_a(32'h1234_5678, 32'h1111_1111, 1'b1);
    check_eq("busy_in_ready_run", 64'(a_in_ready), 64'd0);
    a_in_valid = 1'b1;
    a_in_a     = 32'hDEAD_BEEF;
    a_in_b     = 32'h0BAD_F00D;
    a_in_ci    = 1'b1;
    n = 0;
    while (!a_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("hold_valid_seen", 64'(a_out_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_eq("hold_sum", 64'(a_out_sum), 64'h2345_678A);
      check_eq("hold_in_ready", 64'(a_in_ready), 64'd0);
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("post_hs_out_valid", 64'(a_out_valid), 64'd0);
    check_eq("post_hs_in_ready", 64'(a_in_ready), 64'd1);
    check_eq("idle_sum_retained", 64'(a_out_sum), 64'h2345_678A);
    a_in_valid = 1'b0;
    wait_idle(1'b0);

    // Reset in the second RUN cycle discards the operation
    send_a(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(a_out_valid), 64'd0);
    check_eq("midrst_out_sum", 64'(a_out_sum), 64'd0);
    check_eq("midrst_out_co", 64'(a_out_co), 64'd0);
    check_eq("midrst_in_ready", 64'(a_in_ready), 64'd1);
    qa.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("postrst_out_valid", 64'(a_out_valid), 64'd0);
    send_a(32'h0000_0001, 32'h0000_0001, 1'b0);
    wait_idle(1'b0);

    // Signed-overflow corners plus a few random operations
    send_a(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    send_a(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    send_a(32'h8000_0000, 32'h8000_0000, 1'b0);
    send_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = $urandom;
      send_a(ra, rb, 1'(k[0]));
    end
    wait_idle(1'b0);

    // Single-word configuration: one operation every three cycles
    b_out_ready = 1'b1;
    send_b(16'hFFFF, 16'h0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      prev = acc_b;
      send_b(16'($urandom), 16'($urandom), 1'(k[1]));
      check_eq("b_spacing", 64'(acc_b - prev), 64'd3);
    end
    wait_idle(1'b1);

    check_eq("a_drain", 64'(qa.size()), 64'd0);
    check_eq("b_drain", 64'(qb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
